ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 6 +
 rtl/rr_pick2.sv | 13 +
 rtl/ram_arbiter.sv | 98 +++++++++
 tb/tb_ram_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, port index, burst default.
package ram_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;
   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
   localparam int BURST_MAX_DEFAULT = 4;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the pointer port.
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      pointer,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = (pointer == PORT_A) ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM shared by port A (logger) and port B (display) with
// round-robin arbitration, lockable bursts capped under contention, and read return.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DW        = 8,
   parameter int AW        = 10,
   parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          b_req,
   input  logic          a_we,
   input  logic          b_we,
   input  logic          a_lock,
   input  logic          b_lock,
   input  logic [AW-1:0] a_addr,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] a_din,
   input  logic [DW-1:0] b_din,
   output logic          a_gnt,
   output logic          b_gnt,
   output logic          a_rvalid,
   output logic          b_rvalid,
   output logic [DW-1:0] rdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);
   localparam int CW = $clog2(BURST_MAX + 1);

   state_t        state, state_nxt;
   port_t         ptr, ptr_nxt, rd_port;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          rd_pend;
   logic [1:0]    rr_gnt, gnt;
   logic          at_max, keep_a, keep_b;

   rr_pick2 u_pick (.req({b_req, a_req}), .pointer(ptr), .gnt(rr_gnt));

   // Owner keeps priority only while it still locks and the burst cap is not reached.
   assign at_max = (cnt == CW'(BURST_MAX));
   assign keep_a = (state == OWN_A) && a_req && a_lock && !at_max;
   assign keep_b = (state == OWN_B) && b_req && b_lock && !at_max;

   always_comb begin
      gnt       = 2'b00;
      state_nxt = IDLE;
      cnt_nxt   = '0;
      ptr_nxt   = ptr;
      if (!rst) begin
         if (keep_a)      gnt = 2'b01;
         else if (keep_b) gnt = 2'b10;
         else             gnt = rr_gnt;
      end
      if (gnt[0])      ptr_nxt = PORT_B;
      else if (gnt[1]) ptr_nxt = PORT_A;
      // A capped burst always drops back to IDLE, even if the new winner locks.
      if (keep_a)                         state_nxt = OWN_A;
      else if (keep_b)                    state_nxt = OWN_B;
      else if (state != IDLE && at_max)   state_nxt = IDLE;
      else if (gnt[0] && a_lock)          state_nxt = OWN_A;
      else if (gnt[1] && b_lock)          state_nxt = OWN_B;
      if (state_nxt == OWN_A)
         cnt_nxt = ((state == OWN_A) ? cnt : '0) + CW'(b_req);
      else if (state_nxt == OWN_B)
         cnt_nxt = ((state == OWN_B) ? cnt : '0) + CW'(a_req);
   end

   assign a_gnt    = gnt[0];
   assign b_gnt    = gnt[1];
   assign ram_we   = gnt[0] ? a_we : (gnt[1] ? b_we : 1'b0);
   assign ram_addr = gnt[0] ? a_addr : b_addr;
   assign ram_din  = gnt[0] ? a_din : b_din;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= PORT_A;
         cnt     <= '0;
         rd_pend <= 1'b0;
         rd_port <= PORT_A;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         cnt     <= cnt_nxt;
         rd_pend <= (|gnt) && !ram_we;
         rd_port <= gnt[1] ? PORT_B : PORT_A;
      end
   end

   // Gated by rst so a reset in the return cycle swallows the pending read.
   assign a_rvalid = rd_pend && !rst && (rd_port == PORT_A);
   assign b_rvalid = rd_pend && !rst && (rd_port == PORT_B);
   assign rdata    = (a_rvalid || b_rvalid) ? ram_dout : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_ram_arbiter;
   import ram_arb_pkg::*;
   localparam int DW = 8, AW = 10, BM = 4;

   logic clk = 1'b0, rst;
   logic a_req, b_req, a_we, b_we, a_lock, b_lock;
   logic [AW-1:0] a_addr, b_addr, ram_addr;
   logic [DW-1:0] a_din, b_din, ram_din, ram_dout, rdata;
   logic a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
   int checks = 0, errors = 0;

   ram_arbiter #(.DW(DW), .AW(AW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
      .a_lock(a_lock), .b_lock(b_lock), .a_addr(a_addr), .b_addr(b_addr),
      .a_din(a_din), .b_din(b_din), .a_gnt(a_gnt), .b_gnt(b_gnt),
      .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .rdata(rdata), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

   always #5 clk = ~clk;

   // Synchronous RAM, one-cycle read latency.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (rst) for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      else if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   // Reference model: owner (0 none, 1 A, 2 B), burst length, tie preference, memory image.
   int m_own, m_cnt, new_own, base;
   bit m_pref_b, ea, eb, ka, kb, pend_a, pend_b;
   logic [DW-1:0] pend_data, exp_rd, mmem [0:(1<<AW)-1];
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_din;
   logic exp_we;

   always @(negedge clk) begin
      ka = !rst && m_own == 1 && a_req && a_lock && m_cnt < BM;
      kb = !rst && m_own == 2 && b_req && b_lock && m_cnt < BM;
      if (rst) begin ea = 0; eb = 0; end
      else if (ka) begin ea = 1; eb = 0; end
      else if (kb) begin ea = 0; eb = 1; end
      else if (a_req && b_req) begin ea = !m_pref_b; eb = m_pref_b; end
      else begin ea = a_req; eb = b_req; end
      exp_we   = ea ? a_we : (eb ? b_we : 1'b0);
      exp_addr = ea ? a_addr : b_addr;
      exp_din  = ea ? a_din : b_din;
      exp_rd   = ((pend_a || pend_b) && !rst) ? pend_data : '0;
      checks += 7;
      if (a_gnt !== ea) begin errors++; $display("FAIL mon_a_gnt got %b want %b t=%0t", a_gnt, ea, $time); end
      if (b_gnt !== eb) begin errors++; $display("FAIL mon_b_gnt got %b want %b t=%0t", b_gnt, eb, $time); end
      if (a_gnt && b_gnt) begin errors++; $display("FAIL mon_both_gnt got 1 want 0 t=%0t", $time); end
      if (ram_we !== exp_we || ram_addr !== exp_addr || ram_din !== exp_din) begin
         errors++; $display("FAIL mon_ram_bus got we=%b a=%0h d=%0h want we=%b a=%0h d=%0h t=%0t",
                            ram_we, ram_addr, ram_din, exp_we, exp_addr, exp_din, $time);
      end
      if (a_rvalid !== (pend_a && !rst)) begin errors++; $display("FAIL mon_a_rvalid got %b want %b t=%0t", a_rvalid, pend_a && !rst, $time); end
      if (b_rvalid !== (pend_b && !rst)) begin errors++; $display("FAIL mon_b_rvalid got %b want %b t=%0t", b_rvalid, pend_b && !rst, $time); end
      if (rdata !== exp_rd) begin errors++; $display("FAIL mon_rdata got %0h want %0h t=%0t", rdata, exp_rd, $time); end
      if (rst) begin
         m_own = 0; m_cnt = 0; m_pref_b = 0; pend_a = 0; pend_b = 0; pend_data = '0;
         for (int i = 0; i < (1<<AW); i++) mmem[i] = '0;
      end else begin
         pend_a = ea && !a_we;
         pend_b = eb && !b_we;
         pend_data = ea ? mmem[a_addr] : mmem[b_addr];
         if (ea && a_we) mmem[a_addr] = a_din;
         if (eb && b_we) mmem[b_addr] = b_din;
         if (ea) m_pref_b = 1; else if (eb) m_pref_b = 0;
         if (ka) new_own = 1;
         else if (kb) new_own = 2;
         else if (m_own != 0 && m_cnt >= BM) new_own = 0;
         else if (ea && a_lock) new_own = 1;
         else if (eb && b_lock) new_own = 2;
         else new_own = 0;
         if (new_own == 0) m_cnt = 0;
         else begin
            base  = (new_own == m_own) ? m_cnt : 0;
            m_cnt = base + ((new_own == 1) ? int'(b_req) : int'(a_req));
         end
         m_own = new_own;
      end
   end

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic quiet();
      a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
      a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
   endtask

   task automatic test_reset();
      nxt(); rst = 1; a_req = 1; b_req = 1; a_we = 1;
      @(negedge clk);
      checks += 4;
      if (a_gnt !== 0 || b_gnt !== 0) begin errors++; $display("FAIL reset_gnt got %b%b want 00", a_gnt, b_gnt); end
      if (ram_we !== 0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
      if (a_rvalid !== 0 || b_rvalid !== 0 || rdata !== '0) begin errors++; $display("FAIL reset_rd got %b%b %0h want 00 0", a_rvalid, b_rvalid, rdata); end
      if (dut.state !== IDLE || dut.ptr !== PORT_A || dut.cnt !== '0) begin
         errors++; $display("FAIL reset_regs got st=%0d ptr=%0d cnt=%0d want 0 0 0", dut.state, dut.ptr, dut.cnt);
      end
      nxt(); rst = 0; quiet();
   endtask

   task automatic test_write_read();
      nxt(); a_req = 1; a_we = 1; a_addr = 5; a_din = 8'h3C;
      @(negedge clk);
      checks += 2;
      if (a_gnt !== 1 || b_gnt !== 0) begin errors++; $display("FAIL wr_gnt got %b%b want 01", b_gnt, a_gnt); end
      if (ram_we !== 1 || ram_addr !== 5) begin errors++; $display("FAIL wr_bus got we=%b addr=%0d want 1 5", ram_we, ram_addr); end
      nxt(); quiet(); b_req = 1; b_addr = 5;
      @(negedge clk);
      checks++;
      if (b_gnt !== 1) begin errors++; $display("FAIL rd_gnt got %b want 1", b_gnt); end
      nxt(); quiet();
      @(negedge clk);
      checks += 2;
      if (b_rvalid !== 1 || a_rvalid !== 0) begin errors++; $display("FAIL rd_rvalid got a=%b b=%b want 0 1", a_rvalid, b_rvalid); end
      if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_data got %0h want 3c", rdata); end
   endtask

   task automatic test_round_robin();
      bit want_a, prev_a;
      for (int i = 0; i < 6; i++) begin
         nxt(); a_req = 1; b_req = 1; a_we = 0; b_we = 0;
         a_addr = AW'($urandom_range(0, 7)); b_addr = AW'($urandom_range(0, 7));
         @(negedge clk);
         want_a = (i % 2 == 0);
         checks++;
         if (a_gnt !== want_a || b_gnt !== !want_a) begin errors++; $display("FAIL rr_seq[%0d] got a=%b b=%b want a=%b", i, a_gnt, b_gnt, want_a); end
         if (i > 0) begin
            checks++;
            if (a_rvalid !== prev_a || b_rvalid !== !prev_a) begin errors++; $display("FAIL rr_rvalid[%0d] got a=%b b=%b want a=%b", i, a_rvalid, b_rvalid, prev_a); end
         end
         prev_a = want_a;
      end
      nxt(); quiet();
      @(negedge clk);
      checks++;
      if (b_rvalid !== 1 || a_rvalid !== 0) begin errors++; $display("FAIL rr_last_rvalid got a=%b b=%b want 0 1", a_rvalid, b_rvalid); end
   endtask

   task automatic test_burst();
      logic [5:0] want_b;
      want_b = 6'b010000;  // bit i set: grant i goes to B
      for (int i = 0; i < 6; i++) begin
         nxt(); a_req = 1; b_req = 1; a_lock = 1;
         @(negedge clk);
         checks++;
         if (b_gnt !== want_b[i] || a_gnt !== !want_b[i]) begin errors++; $display("FAIL burst_seq[%0d] got a=%b b=%b want b=%b", i, a_gnt, b_gnt, want_b[i]); end
      end
      nxt(); quiet();
      nxt();
   endtask

   task automatic test_lock_solo();
      for (int i = 0; i < 10; i++) begin
         nxt(); b_req = 1; b_lock = 1; b_we = i[0]; b_addr = AW'(i);
         @(negedge clk);
         checks++;
         if (b_gnt !== 1 || a_gnt !== 0) begin errors++; $display("FAIL solo_gnt[%0d] got a=%b b=%b want 0 1", i, a_gnt, b_gnt); end
         if (i > 0) begin
            checks++;
            if (dut.state !== OWN_B) begin errors++; $display("FAIL solo_state[%0d] got %0d want %0d", i, dut.state, OWN_B); end
         end
      end
      nxt(); b_req = 0;
      nxt(); quiet();
      @(negedge clk);
      checks++;
      if (dut.state !== IDLE) begin errors++; $display("FAIL solo_release got %0d want %0d", dut.state, IDLE); end
   endtask

   task automatic test_reset_read();
      nxt(); quiet(); a_req = 1; a_addr = 3;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1) begin errors++; $display("FAIL rstrd_gnt got %b want 1", a_gnt); end
      nxt(); quiet(); rst = 1;
      @(negedge clk);
      checks++;
      if (a_rvalid !== 0 || rdata !== '0) begin errors++; $display("FAIL rstrd_suppress got rv=%b d=%0h want 0 0", a_rvalid, rdata); end
      nxt();
      @(negedge clk);
      checks++;
      if (dut.state !== IDLE || dut.ptr !== PORT_A || dut.cnt !== '0) begin
         errors++; $display("FAIL rstrd_regs got st=%0d ptr=%0d cnt=%0d want 0 0 0", dut.state, dut.ptr, dut.cnt);
      end
      nxt(); rst = 0; a_req = 1; b_req = 1;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1 || b_gnt !== 0) begin errors++; $display("FAIL rstrd_after got a=%b b=%b want 1 0", a_gnt, b_gnt); end
      nxt(); quiet();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         nxt();
         rst    = ($urandom_range(0, 99) == 0);
         a_req  = ($urandom_range(0, 3) != 0);
         b_req  = ($urandom_range(0, 3) != 0);
         a_lock = ($urandom_range(0, 1) == 1);
         b_lock = ($urandom_range(0, 2) == 0);
         a_we   = ($urandom_range(0, 2) == 0);
         b_we   = ($urandom_range(0, 2) == 0);
         a_addr = AW'($urandom_range(0, 7));
         b_addr = AW'($urandom_range(0, 7));
         a_din  = DW'($urandom);
         b_din  = DW'($urandom);
      end
      nxt(); rst = 0; quiet();
      nxt();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; quiet();
      test_reset();
      test_write_read();
      test_round_robin();
      test_burst();
      test_lock_solo();
      test_reset_read();
      test_random();
      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
